// File: rtl/mem_port_pkg.sv
// rtl/mem_port_pkg.sv - shared RAM write-width type
package mem_port_pkg;
   typedef enum logic [1:0] {
      write_byte     = 2'd0,
      write_halfword = 2'd1,
      write_word     = 2'd2
   } write_width_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data request, response and RAM port bundle
interface mem_port_arbiter_if;
   logic                       if_req_valid;
   logic                       if_req_ready;
   logic [31:0]                if_addr;
   logic                       if_resp_valid;
   logic [31:0]                if_resp_data;
   logic                       d_req_valid;
   logic                       d_req_ready;
   logic [31:0]                d_addr;
   logic                       d_w_enable;
   logic [31:0]                d_w_data;
   mem_port_pkg::write_width_t d_w_width;
   logic                       d_resp_valid;
   logic [31:0]                d_resp_data;
   logic                       d_resp_err;
   logic [31:0]                ram_addr;
   logic [31:0]                ram_w_data;
   mem_port_pkg::write_width_t ram_w_width;
   logic                       ram_w_enable;
   logic [31:0]                ram_r_data;

   modport slave (
      input  if_req_valid, if_addr, d_req_valid, d_addr, d_w_enable, d_w_data, d_w_width, ram_r_data,
      output if_req_ready, if_resp_valid, if_resp_data, d_req_ready, d_resp_valid, d_resp_data,
             d_resp_err, ram_addr, ram_w_data, ram_w_width, ram_w_enable
   );

   modport master (
      output if_req_valid, if_addr, d_req_valid, d_addr, d_w_enable, d_w_data, d_w_width, ram_r_data,
      input  if_req_ready, if_resp_valid, if_resp_data, d_req_ready, d_resp_valid, d_resp_data,
             d_resp_err, ram_addr, ram_w_data, ram_w_width, ram_w_enable
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port RAM between fetch and load/store
// Data wins ties; fetch takes priority after STARVE_LIMIT consecutive losses.
module mem_port_arbiter
   import mem_port_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [2:0] {
      TAG_NONE,
      TAG_IF,
      TAG_D_LOAD,
      TAG_D_STORE,
      TAG_D_ERR
   } tag_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   tag_t       tag;
   logic [3:0] starve_cnt;
   logic       fetch_prio;
   logic       grant_if;
   logic       grant_d;
   logic       misaligned;

   always_comb begin
      misaligned = 1'b0;
      case (bus.d_w_width)
         write_word:     misaligned = (bus.d_addr[1:0] != 2'b00);
         write_halfword: misaligned = bus.d_addr[0];
         default:        misaligned = 1'b0;
      endcase
   end

   // Grants are masked by reset so nothing is ready while reset_n is low.
   assign fetch_prio = (starve_cnt == LIMIT);
   assign grant_if   = reset_n && bus.if_req_valid && (!bus.d_req_valid || fetch_prio);
   assign grant_d    = reset_n && bus.d_req_valid && !grant_if;

   assign bus.if_req_ready = grant_if;
   assign bus.d_req_ready  = grant_d;

   always_comb begin
      bus.ram_addr     = 32'd0;
      bus.ram_w_data   = 32'd0;
      bus.ram_w_width  = write_word;
      bus.ram_w_enable = 1'b0;
      if (grant_if) begin
         bus.ram_addr = bus.if_addr;
      end else if (grant_d) begin
         bus.ram_addr     = bus.d_addr;
         bus.ram_w_data   = bus.d_w_data;
         bus.ram_w_width  = bus.d_w_width;
         bus.ram_w_enable = bus.d_w_enable && !misaligned;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tag        <= TAG_NONE;
         starve_cnt <= 4'd0;
      end else begin
         if (grant_if) begin
            tag <= TAG_IF;
         end else if (grant_d) begin
            if (misaligned)          tag <= TAG_D_ERR;
            else if (bus.d_w_enable) tag <= TAG_D_STORE;
            else                     tag <= TAG_D_LOAD;
         end else begin
            tag <= TAG_NONE;
         end

         if (bus.if_req_valid && !grant_if) begin
            if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
         end else begin
            starve_cnt <= 4'd0;
         end
      end
   end

   // RAM read data arrives the cycle after the grant; the tag routes it.
   assign bus.if_resp_valid = (tag == TAG_IF);
   assign bus.if_resp_data  = (tag == TAG_IF) ? bus.ram_r_data : 32'd0;
   assign bus.d_resp_valid  = (tag == TAG_D_LOAD) || (tag == TAG_D_STORE) || (tag == TAG_D_ERR);
   assign bus.d_resp_data   = (tag == TAG_D_LOAD) ? bus.ram_r_data : 32'd0;
   assign bus.d_resp_err    = (tag == TAG_D_ERR);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - table-driven bench for mem_port_arbiter with a behavioural RAM
module tb_mem_port_arbiter;
   import mem_port_pkg::*;

   logic clock;
   logic reset_n;
   int   n_cmp;
   int   n_bad;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   logic [31:0] mem [0:63];

   always @(posedge clock) begin
      bus.ram_r_data <= mem[bus.ram_addr[7:2]];
      if (bus.ram_w_enable) begin
         case (bus.ram_w_width)
            write_byte:     mem[bus.ram_addr[7:2]][{bus.ram_addr[1:0], 3'b000} +: 8] <= bus.ram_w_data[7:0];
            write_halfword: mem[bus.ram_addr[7:2]][{bus.ram_addr[1], 4'b0000} +: 16] <= bus.ram_w_data[15:0];
            default:        mem[bus.ram_addr[7:2]] <= bus.ram_w_data;
         endcase
      end
   end

   typedef struct {
      logic         if_v;
      logic [31:0]  if_a;
      logic         d_v;
      logic [31:0]  d_a;
      logic         d_we;
      logic [31:0]  d_wd;
      write_width_t d_ww;
      logic         e_if_rdy;
      logic         e_d_rdy;
      logic         e_wen;
      logic [31:0]  e_raddr;
      logic         e_if_rv;
      logic [31:0]  e_if_rd;
      logic         e_d_rv;
      logic [31:0]  e_d_rd;
      logic         e_err;
   } vec_t;

   vec_t vecs [23];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic if_v, input logic [31:0] if_a, input logic d_v, input logic [31:0] d_a,
                        input logic d_we, input logic [31:0] d_wd, input write_width_t d_ww);
      bus.if_req_valid = if_v;
      bus.if_addr      = if_a;
      bus.d_req_valid  = d_v;
      bus.d_addr       = d_a;
      bus.d_w_enable   = d_we;
      bus.d_w_data     = d_wd;
      bus.d_w_width    = d_ww;
   endtask

   task automatic check_reset_outputs(input string tagname);
      chk({tagname, " if_req_ready"},  32'(bus.if_req_ready), 32'd0);
      chk({tagname, " d_req_ready"},   32'(bus.d_req_ready), 32'd0);
      chk({tagname, " ram_w_enable"},  32'(bus.ram_w_enable), 32'd0);
      chk({tagname, " ram_addr"},      bus.ram_addr, 32'd0);
      chk({tagname, " ram_w_data"},    bus.ram_w_data, 32'd0);
      chk({tagname, " ram_w_width"},   32'(bus.ram_w_width), 32'(write_word));
      chk({tagname, " if_resp_valid"}, 32'(bus.if_resp_valid), 32'd0);
      chk({tagname, " if_resp_data"},  bus.if_resp_data, 32'd0);
      chk({tagname, " d_resp_valid"},  32'(bus.d_resp_valid), 32'd0);
      chk({tagname, " d_resp_data"},   bus.d_resp_data, 32'd0);
      chk({tagname, " d_resp_err"},    32'(bus.d_resp_err), 32'd0);
   endtask

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      clock   = 1'b0;
      reset_n = 1'b0;
      bus.ram_r_data = 32'd0;
      for (int i = 0; i < 64; i++) mem[i] = 32'd0;
      mem[0] = 32'h1111_1111;
      mem[1] = 32'h2222_2222;
      mem[2] = 32'h3333_3333;
      mem[8] = 32'hA5A5_0020;

      //          if_v if_a    d_v d_a     we d_wd          ww              ifr dr wen raddr   ifrv if_rd          drv d_rd           err
      vecs[0]  = '{0, 32'h00, 0, 32'h00, 0, 32'h0,        write_word,     0, 0, 0, 32'h00, 0, 32'h0,         0, 32'h0,         0};
      vecs[1]  = '{1, 32'h20, 1, 32'h10, 1, 32'h87654321, write_word,     0, 1, 1, 32'h10, 0, 32'h0,         0, 32'h0,         0};
      vecs[2]  = '{0, 32'h00, 0, 32'h00, 0, 32'h0,        write_word,     0, 0, 0, 32'h00, 0, 32'h0,         1, 32'h0,         0};
      vecs[3]  = '{0, 32'h00, 1, 32'h12, 1, 32'h0000FEDC, write_halfword, 0, 1, 1, 32'h12, 0, 32'h0,         0, 32'h0,         0};
      vecs[4]  = '{0, 32'h00, 1, 32'h10, 0, 32'h0,        write_word,     0, 1, 0, 32'h10, 0, 32'h0,         1, 32'h0,         0};
      vecs[5]  = '{0, 32'h00, 0, 32'h00, 0, 32'h0,        write_word,     0, 0, 0, 32'h00, 0, 32'h0,         1, 32'hFEDC4321,  0};
      vecs[6]  = '{0, 32'h00, 1, 32'h11, 1, 32'hDEADBEEF, write_word,     0, 1, 0, 32'h11, 0, 32'h0,         0, 32'h0,         0};
      vecs[7]  = '{0, 32'h00, 1, 32'h10, 0, 32'h0,        write_word,     0, 1, 0, 32'h10, 0, 32'h0,         1, 32'h0,         1};
      vecs[8]  = '{0, 32'h00, 1, 32'h13, 0, 32'h0,        write_halfword, 0, 1, 0, 32'h13, 0, 32'h0,         1, 32'hFEDC4321,  0};
      vecs[9]  = '{0, 32'h00, 1, 32'h13, 1, 32'h000000AB, write_byte,     0, 1, 1, 32'h13, 0, 32'h0,         1, 32'h0,         1};
      vecs[10] = '{0, 32'h00, 1, 32'h10, 0, 32'h0,        write_word,     0, 1, 0, 32'h10, 0, 32'h0,         1, 32'h0,         0};
      vecs[11] = '{0, 32'h00, 0, 32'h00, 0, 32'h0,        write_word,     0, 0, 0, 32'h00, 0, 32'h0,         1, 32'hABDC4321,  0};
      vecs[12] = '{1, 32'h00, 0, 32'h00, 0, 32'h0,        write_word,     1, 0, 0, 32'h00, 0, 32'h0,         0, 32'h0,         0};
      vecs[13] = '{1, 32'h04, 0, 32'h00, 0, 32'h0,        write_word,     1, 0, 0, 32'h04, 1, 32'h11111111,  0, 32'h0,         0};
      vecs[14] = '{1, 32'h08, 0, 32'h00, 0, 32'h0,        write_word,     1, 0, 0, 32'h08, 1, 32'h22222222,  0, 32'h0,         0};
      vecs[15] = '{0, 32'h00, 0, 32'h00, 0, 32'h0,        write_word,     0, 0, 0, 32'h00, 1, 32'h33333333,  0, 32'h0,         0};
      vecs[16] = '{1, 32'h20, 1, 32'h00, 0, 32'h0,        write_word,     0, 1, 0, 32'h00, 0, 32'h0,         0, 32'h0,         0};
      vecs[17] = '{1, 32'h20, 1, 32'h00, 0, 32'h0,        write_word,     0, 1, 0, 32'h00, 0, 32'h0,         1, 32'h11111111,  0};
      vecs[18] = '{1, 32'h20, 1, 32'h00, 0, 32'h0,        write_word,     0, 1, 0, 32'h00, 0, 32'h0,         1, 32'h11111111,  0};
      vecs[19] = '{1, 32'h20, 1, 32'h00, 0, 32'h0,        write_word,     0, 1, 0, 32'h00, 0, 32'h0,         1, 32'h11111111,  0};
      vecs[20] = '{1, 32'h20, 1, 32'h00, 0, 32'h0,        write_word,     1, 0, 0, 32'h20, 0, 32'h0,         1, 32'h11111111,  0};
      vecs[21] = '{1, 32'h20, 1, 32'h00, 0, 32'h0,        write_word,     0, 1, 0, 32'h00, 1, 32'hA5A50020,  0, 32'h0,         0};
      vecs[22] = '{0, 32'h00, 0, 32'h00, 0, 32'h0,        write_word,     0, 0, 0, 32'h00, 0, 32'h0,         1, 32'h11111111,  0};

      // Reset state, with requests asserted to show readies are masked.
      drive(1, 32'h20, 1, 32'h10, 1, 32'h12345678, write_word);
      repeat (2) @(posedge clock);
      @(negedge clock);
      check_reset_outputs("reset");
      drive(0, 0, 0, 0, 0, 0, write_word);
      reset_n = 1'b1;

      foreach (vecs[i]) begin
         @(posedge clock);
         #1;
         drive(vecs[i].if_v, vecs[i].if_a, vecs[i].d_v, vecs[i].d_a, vecs[i].d_we, vecs[i].d_wd, vecs[i].d_ww);
         @(negedge clock);
         chk($sformatf("v%0d if_req_ready", i),  32'(bus.if_req_ready),  32'(vecs[i].e_if_rdy));
         chk($sformatf("v%0d d_req_ready", i),   32'(bus.d_req_ready),   32'(vecs[i].e_d_rdy));
         chk($sformatf("v%0d ram_w_enable", i),  32'(bus.ram_w_enable),  32'(vecs[i].e_wen));
         chk($sformatf("v%0d ram_addr", i),      bus.ram_addr,           vecs[i].e_raddr);
         chk($sformatf("v%0d if_resp_valid", i), 32'(bus.if_resp_valid), 32'(vecs[i].e_if_rv));
         chk($sformatf("v%0d if_resp_data", i),  bus.if_resp_data,       vecs[i].e_if_rd);
         chk($sformatf("v%0d d_resp_valid", i),  32'(bus.d_resp_valid),  32'(vecs[i].e_d_rv));
         chk($sformatf("v%0d d_resp_data", i),   bus.d_resp_data,        vecs[i].e_d_rd);
         chk($sformatf("v%0d d_resp_err", i),    32'(bus.d_resp_err),    32'(vecs[i].e_err));
      end

      // Three starved cycles, then reset: the counter must restart from zero.
      @(posedge clock);
      #1;
      drive(1, 32'h20, 1, 32'h00, 0, 0, write_word);
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      check_reset_outputs("starve_reset");
      #1;
      reset_n = 1'b1;
      #1;
      chk("post_reset c0 d_req_ready", 32'(bus.d_req_ready), 32'd1);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clock);
         chk($sformatf("post_reset c%0d d_req_ready", k),  32'(bus.d_req_ready),  (k == 4) ? 32'd0 : 32'd1);
         chk($sformatf("post_reset c%0d if_req_ready", k), 32'(bus.if_req_ready), (k == 4) ? 32'd1 : 32'd0);
      end

      // Fetch read of 0x10 granted, then reset lands while its data is due.
      @(posedge clock);
      #1;
      drive(1, 32'h10, 0, 0, 0, 0, write_word);
      @(negedge clock);
      chk("midread grant if_req_ready", 32'(bus.if_req_ready), 32'd1);
      @(posedge clock);
      #1;
      drive(0, 0, 0, 0, 0, 0, write_word);
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midread");
      @(negedge clock);
      reset_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk($sformatf("midread after%0d if_resp_valid", k), 32'(bus.if_resp_valid), 32'd0);
         chk($sformatf("midread after%0d d_resp_valid", k),  32'(bus.d_resp_valid),  32'd0);
         @(negedge clock);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port `ram` block between the instruction-fetch stage (read-only) and the load/store stage (read/write) of the pipelined RV32I core.
- Grants at most one request per cycle and drives the RAM port combinationally from the winner.
- Tracks the one-cycle RAM read latency and routes `r_data` back to the requester that issued it.
- Data port has priority; a starvation counter guarantees forward progress for fetch.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles fetch may be valid-but-ungranted before it wins priority; legal range 1..15.

Ports:
- clock  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- if_req_valid  input  1  fetch request present.
- if_req_ready  output  1  fetch request granted this cycle.
- if_addr  input  32  fetch byte address.
- if_resp_valid  output  1  fetch read data valid, one-cycle pulse.
- if_resp_data  output  32  fetch read data.
- d_req_valid  input  1  data request present.
- d_req_ready  output  1  data request granted this cycle.
- d_addr  input  32  data byte address.
- d_w_enable  input  1  1 = store, 0 = load.
- d_w_data  input  32  store data, right-aligned.
- d_w_width  input  write_width_t  write_byte / write_halfword / write_word.
- d_resp_valid  output  1  data response, one-cycle pulse; issued for loads, stores and errors.
- d_resp_data  output  32  load data; 0 for stores and errors.
- d_resp_err  output  1  misaligned access flag; qualified by d_resp_valid.
- ram_addr  output  32  to ram.addr.
- ram_w_data  output  32  to ram.w_data.
- ram_w_width  output  write_width_t  to ram.w_width.
- ram_w_enable  output  1  to ram.w_enable.
- ram_r_data  input  32  from ram.r_data; valid one cycle after the address is presented.

Behaviour:
- **Reset (reset_n low, async):**
  - All *_ready, *_resp_valid, d_resp_err and ram_w_enable are 0.
  - ram_addr, ram_w_data and all resp_data are 0; ram_w_width = write_word.
  - starve_cnt = 0; the outstanding-response tag is cleared.
  - A read in flight when reset asserts is dropped: no response is issued after reset deasserts.
- **Arbitration (combinational, same cycle):**
  - fetch_prio = (starve_cnt == STARVE_LIMIT).
  - If both requests are valid: data wins unless fetch_prio, in which case fetch wins.
  - If only one request is valid, it wins.
  - The winner's ready = 1 and the loser's ready = 0; neither is ready when the requester is not valid.
  - A request transfers on valid & ready. Requesters hold their request fields stable until ready.
- **RAM drive:**
  - Fetch grant: ram_addr = if_addr, ram_w_enable = 0.
  - Data grant (aligned): ram_addr = d_addr, ram_w_* from the d_* signals, ram_w_enable = d_w_enable.
  - No grant: ram_w_enable = 0, ram_addr = 0.
- **Misalignment:**
  - A misaligned data request is word with d_addr[1:0] != 0, or halfword with d_addr[0] != 0. This applies to loads too, using d_w_width as the access size.
  - It is still granted (d_req_ready = 1), but ram_w_enable is forced to 0.
  - Next cycle: d_resp_valid = 1, d_resp_err = 1, d_resp_data = 0.
- **Response (registered tag {NONE, IF, D_LOAD, D_STORE, D_ERR}, set on grant):**
  - Next cycle, the tagged *_resp_valid pulses for exactly one cycle.
  - Load data = ram_r_data, raw word with no byte extraction; the LSU extracts and sign-extends.
  - D_STORE pulses d_resp_valid with data 0 and err 0.
  - There is no response back-pressure. Throughput is one grant per cycle, back-to-back.
- **Starvation counter (4 bits, saturating at STARVE_LIMIT):**
  - Increments when if_req_valid & !if_req_ready.
  - Clears when a fetch is granted, or when if_req_valid = 0.
- **Simultaneous events:**
  - A grant and the prior response occur in the same cycle independently.
  - A fetch grant with fetch_prio clears the counter that same edge.

Test Plan:
- **Reset mid-read:** fetch read of 0x10 granted; reset_n pulsed low before the next edge → no if_resp_valid after reset; all outputs 0 while low.
- **Data priority:** both valid; d_addr 0x10 store word 0x87654321; if_addr 0x20 →
  - cycle 0: d_req_ready=1, if_req_ready=0, ram_w_enable=1.
  - cycle 1: d_resp_valid=1, d_resp_data=0.
- **Starvation:** d_req_valid held high with loads, fetch valid at 0x20 (STARVE_LIMIT=4) → data granted cycles 0–3; fetch granted cycle 4; if_resp_data = mem[0x20] in cycle 5; data resumes cycle 5.
- **Load return:** store halfword 0xFEDC at 0x12, then load word 0x10 → d_resp_data = 0xFEDC4321 one cycle after grant.
- **Misaligned:** store word to 0x11 → granted, ram_w_enable=0, next cycle d_resp_err=1; a following load word at 0x10 returns unchanged data.
- **Back-to-back:** fetch-only requests at 0x0, 0x4, 0x8 on consecutive cycles → three if_resp_valid pulses on consecutive cycles with matching data.
